fifo_rd_drain: RTL and testbench

Read-side consumer engine for the dual-clock FIFO. It runs entirely in the read clock domain. It watches rempty, issues rinc, and captures rdata when rd_valid is high. Captured words go into a small output buffer, which is presented downstream as a valid/ready stream with burst framing (m_last) and a flush/discard mode. It turns the FIFO's read port into a back-pressurable stream without losing, duplicating or reordering words.

---
 rtl/fifo_rd_drain.sv | 115 +++++++++++
 tb/tb_fifo_rd_drain.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: pulls words from a dual-clock FIFO into a small
// buffer and presents them as a framed valid/ready stream. Optional checker: FIFO_RD_CHK_EN.
module fifo_rd_drain #(
  parameter int DSIZE      = 8,
  parameter int OBUF_DEPTH = 4,
  parameter int BURST      = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic             flush,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rd_valid,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             flush_done,
  output logic             busy,
  output logic             rd_err
);

  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int OW = $clog2(OBUF_DEPTH + 1);
  localparam int CW = OW + 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t           state;
  logic [DSIZE-1:0] mem [OBUF_DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [OW-1:0]    occ;
  logic             pend;
  logic [BW-1:0]    beat;
  logic             push;
  logic             pop;
  logic             done;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts the in-flight read so the buffer can never overflow
  assign rinc = (state != S_IDLE) & ~rempty &
                ((CW'(occ) + CW'(pend)) < CW'(OBUF_DEPTH));

  assign m_valid    = (occ != '0);
  assign m_data     = mem[head];
  assign m_last     = m_valid & (beat == BW'(BURST - 1));
  assign push       = rd_valid & (state != S_FLUSH) & ~flush;
  assign pop        = m_valid & m_ready;
  assign done       = (state == S_FLUSH) & rempty & ~pend & ~flush;
  assign flush_done = done;
  assign busy       = (state != S_IDLE) | (occ != '0) | pend;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= S_IDLE;
      occ   <= '0;
      pend  <= 1'b0;
      beat  <= '0;
      head  <= '0;
      tail  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      pend <= rinc;
      if (flush) begin
        state <= S_FLUSH;
        occ   <= '0;
        beat  <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        unique case (state)
          S_IDLE:  if (en) state <= S_RUN;
          S_RUN:   if (!en) state <= S_IDLE;
          S_FLUSH: if (done) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
        if (push) begin
          mem[tail] <= rdata;
          tail      <= nxt(tail);
        end
        if (pop) begin
          head <= nxt(head);
          beat <= (beat == BW'(BURST - 1)) ? '0 : beat + 1'b1;
        end
        occ <= occ + OW'(push) - OW'(pop);
      end
    end
  end

`ifdef FIFO_RD_CHK_EN
  // Sticky: any read-port handshake anomaly latches until reset
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rd_err <= 1'b0;
    end else if ((rd_valid & ~pend) | (pend & ~rd_valid) |
                 (rinc & rempty)) begin
      rd_err <= 1'b1;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: queue-based FIFO source and stream model,
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_fifo_rd_drain;

  localparam int W = 8;
  localparam int D = 4;
  localparam int B = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FL   = 2;

  logic         rclk = 1'b0;
  logic         rrst;
  logic         en;
  logic         flush;
  logic         rempty;
  logic [W-1:0] rdata;
  logic         rd_valid;
  logic         rinc;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         flush_done;
  logic         busy;
  logic         rd_err;

  fifo_rd_drain #(.DSIZE(W), .OBUF_DEPTH(D), .BURST(B)) dut (
    .rclk(rclk), .rrst(rrst), .en(en), .flush(flush),
    .rempty(rempty), .rdata(rdata), .rd_valid(rd_valid),
    .rinc(rinc), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last),
    .flush_done(flush_done), .busy(busy), .rd_err(rd_err)
  );

  always #5 rclk = ~rclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk = 0;
  int n_pass = 0;

  // model state
  logic [W-1:0] src_q[$];
  logic [W-1:0] obuf[$];
  int ms = M_IDLE;
  bit mpend = 0;
  int mbeat = 0;
  logic [W-1:0] wval = '0;

  // observations of the DUT for literal checks
  int cyc = 0;
  logic [W-1:0] got[$];
  logic [W-1:0] lastd[$];
  int n_rinc, cur_run, max_run, first_rinc, first_valid;
  int n_fd, fd_cyc, rv_cyc, n_mv, last_idx;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  task automatic clr();
    got.delete();
    lastd.delete();
    n_rinc = 0; cur_run = 0; max_run = 0;
    first_rinc = -1; first_valid = -1;
    n_fd = 0; fd_cyc = -1; rv_cyc = -1; n_mv = 0; last_idx = -1;
  endtask

  task automatic feed(int n);
    repeat (n) begin
      src_q.push_back(wval);
      wval = wval + 1'b1;
    end
    rempty = (src_q.size() == 0);
  endtask

  task automatic cycle();
    bit e_rinc, e_valid, e_last, e_busy, e_done, tpop;
    @(negedge rclk);
    cyc++;
    e_rinc  = (ms != M_IDLE) && (src_q.size() != 0) &&
              (obuf.size() + int'(mpend) < D);
    e_valid = (obuf.size() != 0);
    e_last  = e_valid && (mbeat == B - 1);
    e_busy  = (ms != M_IDLE) || (obuf.size() != 0) || mpend;
    e_done  = (ms == M_FL) && (src_q.size() == 0) && !mpend && !flush;
    chk("rinc", rinc, e_rinc);
    chk("m_valid", m_valid, e_valid);
    if (e_valid) chk("m_data", m_data, obuf[0]);
    chk("m_last", m_last, e_last);
    chk("busy", busy, e_busy);
    chk("flush_done", flush_done, e_done);
    chk("rd_err", rd_err, 0);
    if (rinc) begin
      n_rinc++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (first_rinc < 0) first_rinc = cyc;
    end else cur_run = 0;
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (m_valid) n_mv++;
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      if (m_last) begin
        lastd.push_back(m_data);
        if (last_idx < 0) last_idx = got.size();
      end
    end
    if (flush_done) begin n_fd++; fd_cyc = cyc; end
    if (rd_valid) rv_cyc = cyc;
    @(posedge rclk);
    tpop = (obuf.size() != 0) && m_ready;
    if (flush) begin
      ms = M_FL;
      obuf.delete();
      mbeat = 0;
    end else begin
      if (tpop) begin
        void'(obuf.pop_front());
        mbeat = (mbeat + 1) % B;
      end
      if (rd_valid && ms != M_FL) obuf.push_back(rdata);
      case (ms)
        M_IDLE: if (en) ms = M_RUN;
        M_RUN:  if (!en) ms = M_IDLE;
        default: if (e_done) ms = M_IDLE;
      endcase
    end
    mpend = e_rinc;
    #1;
    if (e_rinc) begin
      rdata = src_q.pop_front();
      rd_valid = 1'b1;
    end else begin
      rd_valid = 1'b0;
    end
    rempty = (src_q.size() == 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rinc"}, rinc, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_flush_done"}, flush_done, 0);
    chk({tag, "_rd_err"}, rd_err, 0);
  endtask

  initial begin
    int errs, k, base;
    rrst = 1'b1; en = 0; flush = 0; m_ready = 0;
    rempty = 1'b1; rdata = '0; rd_valid = 0;
    clr();
    #3;
    chk_zero("reset");
    @(posedge rclk);
    @(posedge rclk);
    #1 rrst = 1'b0;

    // 1: straight stream of 20 words
    clr();
    feed(20);
    en = 1; m_ready = 1;
    for (int i = 0; i < 60 && got.size() < 20; i++) cycle();
    en = 0;
    repeat (3) cycle();
    chk("p1_count", got.size(), 20);
    errs = 0;
    foreach (got[i]) if (got[i] != W'(i)) errs++;
    chk("p1_order", errs, 0);
    chk("p1_rinc_total", n_rinc, 20);
    chk("p1_rinc_run", max_run, 20);
    chk("p1_latency", first_valid - first_rinc, 2);
    chk("p1_nlast", lastd.size(), 1);
    if (lastd.size() > 0) chk("p1_last_word", lastd[0], 8'h0F);
    chk("p1_idle", busy, 0);

    // 2: backpressure fills the buffer and stops reads
    clr();
    m_ready = 0;
    base = int'(wval);
    feed(10);
    en = 1;
    repeat (12) cycle();
    chk("p2_rinc_pulses", n_rinc, 4);
    chk("p2_rinc_low", rinc, 0);
    chk("p2_head", m_data, base);
    m_ready = 1;
    for (int i = 0; i < 60 && got.size() < 10; i++) cycle();
    chk("p2_count", got.size(), 10);
    errs = 0;
    foreach (got[i]) if (got[i] != W'(base + i)) errs++;
    chk("p2_order", errs, 0);
    en = 0;
    repeat (3) cycle();

    // 3: flush with 3 buffered and 5 in the FIFO
    m_ready = 0;
    en = 1;
    feed(3);
    repeat (8) cycle();
    en = 0;
    repeat (2) cycle();
    feed(5);
    chk("p3_buffered", m_valid, 1);
    flush = 1;
    cycle();
    flush = 0;
    clr();
    for (int i = 0; i < 30 && n_fd == 0; i++) cycle();
    repeat (3) cycle();
    chk("p3_rinc", n_rinc, 5);
    chk("p3_fd_pulses", n_fd, 1);
    chk("p3_fd_timing", fd_cyc, rv_cyc + 1);
    chk("p3_no_valid", n_mv, 0);
    chk("p3_idle", busy, 0);

    // 4: en drops mid-stream
    clr();
    m_ready = 1;
    base = int'(wval);
    feed(20);
    en = 1;
    for (int i = 0; i < 40 && got.size() < 5; i++) cycle();
    en = 0;
    cycle();
    k = n_rinc;
    repeat (8) cycle();
    chk("p4_rinc_stop", n_rinc, k);
    chk("p4_delivered", got.size(), k);
    chk("p4_left", src_q.size(), 20 - k);
    errs = 0;
    foreach (got[i]) if (got[i] != W'(base + i)) errs++;
    chk("p4_order", errs, 0);
    chk("p4_idle", busy, 0);

    // 5: asynchronous reset mid-burst
    m_ready = 1;
    en = 1;
    repeat (6) cycle();
    #2;
    rrst = 1'b1;
    rd_valid = 1'b0;
    #1;
    chk_zero("arst");
    @(posedge rclk);
    #1 rrst = 1'b0;
    obuf.delete();
    mpend = 0; ms = M_IDLE; mbeat = 0;
    clr();
    feed(30);
    for (int i = 0; i < 60 && lastd.size() == 0; i++) cycle();
    chk("p5_last_beat", last_idx, 16);

    // 6: randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle();
      en = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      if (src_q.size() < 12 && $urandom_range(0, 1) == 1)
        feed($urandom_range(1, 3));
    end
    flush = 0; en = 0; m_ready = 1;
    repeat (12) cycle();
    chk("p6_idle", busy, 0);

    // 7: unsolicited rd_valid
    @(posedge rclk);
    #1 rd_valid = 1'b1;
    @(posedge rclk);
    #1 rd_valid = 1'b0;
    @(negedge rclk);
`ifdef FIFO_RD_CHK_EN
    chk("p7_err_set", rd_err, 1);
    repeat (3) @(negedge rclk);
    chk("p7_err_sticky", rd_err, 1);
`else
    chk("p7_err_tied", rd_err, 0);
    repeat (3) @(negedge rclk);
    chk("p7_err_still", rd_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
